// File: rtl/matrix_inv_sequencer_if.sv
// Element-load and result-drain stream bundle for matrix_inv_sequencer.
// The master side loads elements and drains results; the slave side is the inverter.
interface matrix_inv_sequencer_if #(
  parameter int unsigned W = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic signed [W-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [W-1:0]   out_data;
  logic [3:0]            out_idx;
  logic                  out_last;
  logic signed [3*W+2:0] det;
  logic                  singular;
  logic                  busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, det, singular, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, det, singular, busy
  );
endinterface

// File: rtl/matrix_inv_sequencer.sv
// Sequential 3x3 signed matrix inverter: adjugate and determinant on one shared
// multiplier, then one shared divider scales each adjugate term per output beat.
module matrix_inv_sequencer #(
  parameter int unsigned W = 8
) (
  input logic                   clk,
  input logic                   rst,
  matrix_inv_sequencer_if.slave bus
);
  localparam int unsigned PW = 2 * W;       // 2x2 product
  localparam int unsigned CW = 2 * W + 1;   // cofactor
  localparam int unsigned DW = 3 * W + 3;   // determinant / divider
  localparam int unsigned MW = CW + W;      // shared multiplier result

  typedef enum logic [1:0] {LOAD, COF, DET, OUT} state_t;

  state_t state, state_nxt;

  logic [4:0]            cnt;
  logic signed [W-1:0]   elem [9];
  logic signed [CW-1:0]  cof  [9];
  logic signed [PW-1:0]  p0;
  logic signed [DW-1:0]  det_acc;
  logic signed [DW-1:0]  det_r;
  logic [3:0]            idx;
  logic                  in_ready_r;
  logic                  out_valid_r;
  logic                  out_last_r;
  logic                  singular_r;
  logic                  busy_r;
  logic signed [W-1:0]   out_data_r;

  logic                  accept_c;
  logic [15:0]           pair_c;
  logic [7:0]            sel_c;
  logic [3:0]            cidx_c;
  logic signed [W-1:0]   mul_a_c;
  logic signed [CW-1:0]  mul_b_c;
  logic signed [MW-1:0]  prod_c;
  logic signed [PW-1:0]  prod_lo_c;
  logic signed [DW-1:0]  det_sum_c;
  logic [3:0]            idx_next_c;
  logic signed [DW-1:0]  dvd_c;
  logic signed [DW-1:0]  dvs_c;
  logic signed [DW-1:0]  dvs_safe_c;
  logic signed [DW-1:0]  quot_c;
  logic signed [W-1:0]   q_sat_c;
  logic signed [W-1:0]   div_res_c;

  // Element indices {p0 x, p0 y, p1 x, p1 y} for cofactor k = p0 - p1 (row-major b11..b33).
  function automatic logic [15:0] cof_pair(input logic [3:0] k);
    logic [15:0] r;
    r = '0;
    case (k)
      4'd0:    r = {4'd4, 4'd8, 4'd5, 4'd7};
      4'd1:    r = {4'd2, 4'd7, 4'd1, 4'd8};
      4'd2:    r = {4'd1, 4'd5, 4'd2, 4'd4};
      4'd3:    r = {4'd5, 4'd6, 4'd3, 4'd8};
      4'd4:    r = {4'd0, 4'd8, 4'd2, 4'd6};
      4'd5:    r = {4'd2, 4'd3, 4'd0, 4'd5};
      4'd6:    r = {4'd3, 4'd7, 4'd4, 4'd6};
      4'd7:    r = {4'd1, 4'd6, 4'd0, 4'd7};
      4'd8:    r = {4'd0, 4'd4, 4'd1, 4'd3};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign accept_c = (state == LOAD) && bus.in_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD: if (accept_c && cnt == 5'd8)             state_nxt = COF;
      COF:  if (cnt == 5'd17)                        state_nxt = DET;
      DET:  if (cnt == 5'd2)                         state_nxt = OUT;
      OUT:  if (bus.out_ready && idx == 4'd8)        state_nxt = LOAD;
      default:                                       state_nxt = LOAD;
    endcase
  end

  // Shared multiplier: 2x2 minor terms in COF, a1j * cofactor in DET
  always_comb begin
    pair_c  = cof_pair(cnt[4:1]);
    sel_c   = cnt[0] ? pair_c[7:0] : pair_c[15:8];
    cidx_c  = 4'({cnt[1:0], 1'b0}) + 4'(cnt[1:0]);
    mul_a_c = elem[sel_c[7:4]];
    mul_b_c = CW'(elem[sel_c[3:0]]);
    if (state == DET) begin
      mul_a_c = elem[4'(cnt[1:0])];
      mul_b_c = cof[cidx_c];
    end
    prod_c    = MW'(mul_a_c) * MW'(mul_b_c);
    prod_lo_c = prod_c[PW-1:0];
    det_sum_c = (cnt == 5'd0) ? DW'(prod_c) : det_acc + DW'(prod_c);
  end

  // Shared divider: the first quotient uses the determinant as it completes
  always_comb begin
    idx_next_c = (idx == 4'd8) ? 4'd0 : idx + 4'd1;
    if (state == DET) begin
      dvd_c = DW'(cof[0]);
      dvs_c = det_sum_c;
    end else begin
      dvd_c = DW'(cof[idx_next_c]);
      dvs_c = det_r;
    end
    dvs_safe_c = (dvs_c == '0) ? DW'(1) : dvs_c;
    quot_c     = dvd_c / dvs_safe_c;
    if (quot_c[DW-1:W-1] == {(DW-W+1){quot_c[DW-1]}})
      q_sat_c = quot_c[W-1:0];
    else
      q_sat_c = quot_c[DW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    div_res_c = (dvs_c == '0) ? '0 : q_sat_c;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      p0          <= '0;
      det_acc     <= '0;
      det_r       <= '0;
      idx         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      singular_r  <= 1'b0;
      busy_r      <= 1'b0;
      out_data_r  <= '0;
      for (int i = 0; i < 9; i++) begin
        elem[i] <= '0;
        cof[i]  <= '0;
      end
    end else begin
      in_ready_r <= (state_nxt == LOAD);
      busy_r     <= (state_nxt != LOAD);
      unique case (state)
        LOAD: begin
          if (accept_c) begin
            elem[cnt[3:0]] <= bus.in_data;
            cnt            <= (cnt == 5'd8) ? 5'd0 : cnt + 5'd1;
          end
        end
        COF: begin
          if (!cnt[0]) p0 <= prod_lo_c;
          else         cof[cnt[4:1]] <= CW'(p0) - CW'(prod_lo_c);
          cnt <= (cnt == 5'd17) ? 5'd0 : cnt + 5'd1;
        end
        DET: begin
          det_acc <= det_sum_c;
          if (cnt == 5'd2) begin
            cnt         <= '0;
            det_r       <= det_sum_c;
            singular_r  <= (det_sum_c == '0);
            out_valid_r <= 1'b1;
            out_data_r  <= div_res_c;
            out_last_r  <= 1'b0;
            idx         <= '0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            if (idx == 4'd8) begin
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              out_data_r  <= '0;
              idx         <= '0;
            end else begin
              idx        <= idx_next_c;
              out_data_r <= div_res_c;
              out_last_r <= (idx_next_c == 4'd8);
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_idx   = idx;
  assign bus.out_last  = out_last_r;
  assign bus.det       = det_r;
  assign bus.singular  = singular_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_matrix_inv_sequencer.sv
// Bench for matrix_inv_sequencer: fixed vector table, backpressure and reset
// sequences, and random matrices checked against an adjugate/determinant model.
module tb_matrix_inv_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_inv_sequencer_if #(.W(8)) bus ();
  matrix_inv_sequencer #(.W(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct packed {
    logic [8:0][7:0]    m;
    logic [8:0][7:0]    res;
    logic signed [31:0] det;
    logic               sing;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int cur_m   [9];
  int exp_res [9];
  int exp_det;
  bit exp_sing;
  vec_t vecs [5];

  function automatic logic [71:0] pack9(input int v0, input int v1, input int v2,
                                        input int v3, input int v4, input int v5,
                                        input int v6, input int v7, input int v8);
    return {8'(v8), 8'(v7), 8'(v6), 8'(v5), 8'(v4), 8'(v3), 8'(v2), 8'(v1), 8'(v0)};
  endfunction

  task automatic check(input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Inverse from the textbook definition: signed 2x2 minors, transposed, divided by det.
  function automatic void ref_model();
    int c [3][3];
    int r0, r1, k0, k1, q;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        r0 = (i == 0) ? 1 : 0;
        r1 = (i == 2) ? 1 : 2;
        k0 = (j == 0) ? 1 : 0;
        k1 = (j == 2) ? 1 : 2;
        c[i][j] = cur_m[r0*3+k0] * cur_m[r1*3+k1] - cur_m[r0*3+k1] * cur_m[r1*3+k0];
        if (((i + j) % 2) == 1) c[i][j] = -c[i][j];
      end
    end
    exp_det = 0;
    for (int j = 0; j < 3; j++) exp_det += cur_m[j] * c[0][j];
    exp_sing = (exp_det == 0);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        if (exp_det == 0) q = 0;
        else              q = c[k][r] / exp_det;
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        exp_res[r*3+k] = q;
      end
    end
  endfunction

  // Nine beats of cur_m; returns at the negedge one cycle after the 9th accept.
  task automatic load_matrix();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("in_ready_load", longint'(bus.in_ready), longint'(1));
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(cur_m[i]);
      @(posedge clk);
    end
    @(negedge clk);
    check("in_ready_after_9th", longint'(bus.in_ready), longint'(0));
    bus.in_data = 8'h5a;
  endtask

  task automatic drain(input bit chk_lat, input int stall_beat, input bit rnd_ready);
    int cyc = 1;
    int beat = 0;
    int guard = 0;
    int stall = 0;
    bit rdy;
    while (!bus.out_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
      bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    if (!bus.out_valid) begin
      check("out_valid_timeout", longint'(0), longint'(1));
      return;
    end
    if (chk_lat) check("latency", longint'(cyc), longint'(22));
    check("busy_out", longint'(bus.busy), longint'(1));
    while (beat < 9 && guard < 300) begin
      check("out_valid", longint'(bus.out_valid), longint'(1));
      check("out_idx", longint'(bus.out_idx), longint'(beat));
      check("out_data", longint'(bus.out_data), longint'(exp_res[beat]));
      check("out_last", longint'(bus.out_last), longint'(beat == 8));
      check("det", longint'(bus.det), longint'(exp_det));
      check("singular", longint'(bus.singular), longint'(exp_sing));
      rdy = 1'b1;
      if (rnd_ready) rdy = ($urandom_range(0, 3) != 0);
      if (beat == stall_beat && stall < 5) begin
        rdy = 1'b0;
        stall++;
      end
      bus.out_ready = rdy;
      @(negedge clk);
      guard++;
      if (rdy) beat++;
    end
    bus.out_ready = 1'b0;
    if (beat < 9) check("beat_timeout", longint'(beat), longint'(9));
    check("valid_after_last", longint'(bus.out_valid), longint'(0));
    check("last_after_last", longint'(bus.out_last), longint'(0));
    check("busy_after_last", longint'(bus.busy), longint'(0));
    check("in_ready_after_last", longint'(bus.in_ready), longint'(1));
  endtask

  task automatic set_identity();
    for (int i = 0; i < 9; i++) begin
      cur_m[i]   = (i % 4 == 0) ? 1 : 0;
      exp_res[i] = cur_m[i];
    end
    exp_det  = 1;
    exp_sing = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{m: pack9(1,0,0,0,1,0,0,0,1), res: pack9(1,0,0,0,1,0,0,0,1), det: 1, sing: 1'b0};
    vecs[1] = '{m: pack9(1,0,1,0,1,0,1,0,1), res: pack9(0,0,0,0,0,0,0,0,0), det: 0, sing: 1'b1};
    vecs[2] = '{m: pack9(2,0,0,0,1,0,0,0,1), res: pack9(0,0,0,0,1,0,0,0,1), det: 2, sing: 1'b0};
    vecs[3] = '{m: pack9(-1,0,0,0,1,0,0,0,1), res: pack9(-1,0,0,0,1,0,0,0,1), det: -1, sing: 1'b0};
    vecs[4] = '{m: pack9(1,127,0,0,1,127,0,0,1), res: pack9(1,-127,127,0,1,-127,0,0,1),
                det: 1, sing: 1'b0};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", longint'(bus.in_ready), longint'(1));
    check("rst_out_valid", longint'(bus.out_valid), longint'(0));
    check("rst_out_data", longint'(bus.out_data), longint'(0));
    check("rst_out_idx", longint'(bus.out_idx), longint'(0));
    check("rst_out_last", longint'(bus.out_last), longint'(0));
    check("rst_det", longint'(bus.det), longint'(0));
    check("rst_singular", longint'(bus.singular), longint'(0));
    check("rst_busy", longint'(bus.busy), longint'(0));

    // Fixed vectors with constant expectations
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 9; i++) begin
        cur_m[i]   = int'($signed(vecs[k].m[i]));
        exp_res[i] = int'($signed(vecs[k].res[i]));
      end
      exp_det  = int'(vecs[k].det);
      exp_sing = vecs[k].sing;
      load_matrix();
      drain(1'b1, -1, 1'b0);
    end

    // Five-cycle stall at beat 3
    cur_m = '{2, 1, 0, 1, 3, 1, 0, 1, 2};
    ref_model();
    load_matrix();
    drain(1'b0, 3, 1'b0);

    // Reset during COF cycle 7, then a clean identity
    set_identity();
    cur_m[0] = 3;
    load_matrix();
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_mid_cof", longint'(bus.busy), longint'(1));
    check("in_ready_mid_cof", longint'(bus.in_ready), longint'(0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", longint'(bus.in_ready), longint'(1));
    check("abort_out_valid", longint'(bus.out_valid), longint'(0));
    check("abort_busy", longint'(bus.busy), longint'(0));
    check("abort_det", longint'(bus.det), longint'(0));
    set_identity();
    load_matrix();
    drain(1'b1, -1, 1'b0);

    // Random matrices, random consumer backpressure
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 9; i++) begin
        if (t % 2 == 1) cur_m[i] = int'($urandom_range(0, 8)) - 4;
        else            cur_m[i] = int'($urandom_range(0, 255)) - 128;
      end
      ref_model();
      load_matrix();
      drain(1'b1, -1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
